// File: rtl/ecg_cnn_mul_rr_arbiter_if.sv
// Bundle of the request (NUM_REQ lanes) and response signals around the
// shared 9x11 multiplier. "master" is the requester/consumer side,
// "slave" is the arbiter.
interface ecg_cnn_mul_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 9,
    parameter int B_W     = 11,
    parameter int P_W     = 19,
    parameter int CNT_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_prod;
    logic [CNT_W-1:0]       op_cnt;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, op_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod, op_cnt
    );
endinterface

// File: rtl/ecg_cnn_mul_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned A_W x B_W multiplier between
// NUM_REQ requesters. One registered response slot tagged with the owning
// requester index; a new product can be loaded in the same cycle the old
// one drains, so throughput is one product per cycle.
// P_W must not exceed A_W+B_W (the product is truncated to its P_W LSBs).
module ecg_cnn_mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W     = 9,
    parameter int B_W     = 11,
    parameter int P_W     = 19,
    parameter int CNT_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    ecg_cnn_mul_rr_arbiter_if.slave  bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int FULL_W = A_W + B_W;
    // Pointer starts at the last lane so lane 0 has first priority.
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
    logic [P_W-1:0]      rsp_prod_q,  rsp_prod_d;
    logic [CNT_W-1:0]    op_cnt_q,    op_cnt_d;
    logic [ID_W-1:0]     ptr_q,       ptr_d;

    logic                adv_s;
    logic                found_s;
    logic [ID_W-1:0]     gid_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [A_W-1:0]      sel_a_s;
    logic [B_W-1:0]      sel_b_s;
    logic [FULL_W-1:0]   prod_full_s;

    // Grant: first valid lane after ptr (wrapping), only when the slot can advance.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        gid_s   = '0;
        grant_s = '0;
        adv_s   = !rsp_valid_q || bus.rsp_ready;
        if (adv_s && !ap_rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!found_s && bus.req_valid[idx]) begin
                    found_s = 1'b1;
                    gid_s   = ID_W'(idx);
                end
            end
            if (found_s) begin
                grant_s = NUM_REQ'(1) << gid_s;
            end else begin
                grant_s = '0;
            end
        end else begin
            found_s = 1'b0;
            grant_s = '0;
        end
    end

    // Operand select and the single shared multiplier.
    always_comb begin
        sel_a_s     = bus.req_a[gid_s*A_W +: A_W];
        sel_b_s     = bus.req_b[gid_s*B_W +: B_W];
        prod_full_s = FULL_W'(sel_a_s) * FULL_W'(sel_b_s);
    end

    // Next state of the response slot, pointer and operation counter.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        op_cnt_d    = op_cnt_q;
        ptr_d       = ptr_q;
        if (found_s) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gid_s;
            rsp_prod_d  = prod_full_s[P_W-1:0];
            op_cnt_d    = op_cnt_q + CNT_W'(1);
            ptr_d       = gid_s;
        end else if (adv_s) begin
            // Slot drained (or already empty) and nothing to load: id/prod keep last values.
            rsp_valid_d = 1'b0;
        end else begin
            // Backpressure: everything holds.
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with synchronous reset; a pending response is dropped.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
            op_cnt_q    <= '0;
            ptr_q       <= PTR_RST;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
            op_cnt_q    <= op_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign bus.op_cnt    = op_cnt_q;

endmodule
